// File: rtl/wbu_buffered.sv
// -----------------------------------------------------------------------------
// wbu_buffered
//
// Buffered writeback stage between the memory stage and the register file /
// CSR unit.
//
// Completed instructions are formatted on entry and pushed into a small FIFO
// with valid/ready handshakes on both sides. Backpressure from the register
// file or CSR unit therefore only fills the FIFO; it never reaches the memory
// stage through combinational logic.
//
// Every output is derived from registered FIFO state only.
//
// Ports
//   clock, reset     system clock; asynchronous active-high reset
//   flush            synchronous; discards all buffered entries
//
//   Upstream side (memory stage):
//     in_valid / in_ready  handshake
//     mem_rdata            raw memory word, used for load formatting
//     ex_result            ALU result / load address
//     rd_value             link or CSR read value
//     rd                   destination register index
//     csr_wen              CSR write enables
//     r_wen                register write request
//     mem_ren              the instruction is a load
//     mem_funct3           load type
//     jump_flag            the instruction is JAL/JALR
//     pc                   instruction PC
//
//   Downstream side (register file / CSR unit):
//     out_valid / out_ready  handshake
//     r_wen_next             register write strobe
//     rd_next                write index
//     rd_value_next          write data
//     csr_wen_next           CSR enables
//     csrd                   CSR write data (the head entry's ex_result)
//     pc_out                 head PC
//     instret                64-bit retired-instruction counter
// -----------------------------------------------------------------------------
module wbu_buffered #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CSR_W   = 4,
  parameter int DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic [XLEN-1:0]    ex_result,
  input  logic [XLEN-1:0]    rd_value,
  input  logic [RADDR_W-1:0] rd,
  input  logic [CSR_W-1:0]   csr_wen,
  input  logic               r_wen,
  input  logic               mem_ren,
  input  logic [2:0]         mem_funct3,
  input  logic               jump_flag,
  input  logic [XLEN-1:0]    pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               r_wen_next,
  output logic [RADDR_W-1:0] rd_next,
  output logic [XLEN-1:0]    rd_value_next,
  output logic [CSR_W-1:0]   csr_wen_next,
  output logic [XLEN-1:0]    csrd,
  output logic [XLEN-1:0]    pc_out,
  output logic [63:0]        instret
);

  // A 1-bit pointer is still used when DEPTH is 1; the explicit wrap in
  // ptr_inc keeps it at zero in that case.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    ex;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rd;
    logic [CSR_W-1:0]   csr_wen;
    logic               r_wen;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Load formatting
  // ---------------------------------------------------------------------------
  logic [1:0]      ld_off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign ld_off = ex_result[1:0];

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (ld_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
  end

  // A halfword is taken from the upper or lower half only.
  // The low address bit is deliberately ignored (no misaligned halfwords).
  assign ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (mem_funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result select and the incoming entry
  // ---------------------------------------------------------------------------
  // Jumps and CSR instructions write back rd_value (the link address or the
  // old CSR value). This takes priority over the load path.
  entry_t in_entry;

  always_comb begin
    in_entry         = '0;
    in_entry.ex      = ex_result;
    in_entry.pc      = pc;
    in_entry.rd      = rd;
    in_entry.csr_wen = csr_wen;
    in_entry.r_wen   = r_wen;

    if (jump_flag || (|csr_wen)) begin
      in_entry.result = rd_value;
    end else if (mem_ren) begin
      in_entry.result = ld_data;
    end else begin
      in_entry.result = ex_result;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q,   count_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [63:0]      instret_q, instret_d;
  logic             push, pop;

  // in_ready looks only at the occupancy, never at out_ready.
  // A full FIFO therefore stays not-ready in the cycle it pops.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    instret_d = instret_q;

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end

      if (pop) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        instret_d = instret_q + 64'd1;
      end

      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      instret_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      instret_q <= instret_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // Entries are not reset. Every output is gated by out_valid, so stale
  // contents are never visible.
  entry_t entry_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        entry_q[gi] <= in_entry;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  entry_t head;

  assign head = entry_q[rd_ptr_q];

  always_comb begin
    r_wen_next    = 1'b0;
    rd_next       = '0;
    rd_value_next = '0;
    csr_wen_next  = '0;
    csrd          = '0;
    pc_out        = '0;

    if (out_valid) begin
      // A write to x0 is never passed on to the register file.
      r_wen_next    = head.r_wen && (head.rd != '0);
      rd_next       = head.rd;
      rd_value_next = head.result;
      csr_wen_next  = head.csr_wen;
      csrd          = head.ex;
      pc_out        = head.pc;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wbu_buffered.sv
// -----------------------------------------------------------------------------
// tb_wbu_buffered
//
// Directed testbench for wbu_buffered.
//
// A queue-based reference model predicts every output. A compare process
// checks the DUT against that model on each falling clock edge. The driver
// also checks hand-computed literal values at key points.
// -----------------------------------------------------------------------------
module tb_wbu_buffered;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ex_result;
  logic [31:0] rd_value;
  logic [4:0]  rd;
  logic [3:0]  csr_wen;
  logic        r_wen;
  logic        mem_ren;
  logic [2:0]  mem_funct3;
  logic        jump_flag;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic        r_wen_next;
  logic [4:0]  rd_next;
  logic [31:0] rd_value_next;
  logic [3:0]  csr_wen_next;
  logic [31:0] csrd;
  logic [31:0] pc_out;
  logic [63:0] instret;

  int vectors     = 0;
  int miscompares = 0;

  wbu_buffered #(
    .XLEN    (32),
    .RADDR_W (5),
    .CSR_W   (4),
    .DEPTH   (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_rdata     (mem_rdata),
    .ex_result     (ex_result),
    .rd_value      (rd_value),
    .rd            (rd),
    .csr_wen       (csr_wen),
    .r_wen         (r_wen),
    .mem_ren       (mem_ren),
    .mem_funct3    (mem_funct3),
    .jump_flag     (jump_flag),
    .pc            (pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .r_wen_next    (r_wen_next),
    .rd_next       (rd_next),
    .rd_value_next (rd_value_next),
    .csr_wen_next  (csr_wen_next),
    .csrd          (csrd),
    .pc_out        (pc_out),
    .instret       (instret)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] res;
    logic [31:0] ex;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [3:0]  csr;
    logic        rw;
  } ment_t;

  ment_t       mq[$];
  logic [63:0] m_instret = 64'd0;

  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    int unsigned b;
    int unsigned h;

    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;

    case (f3)
      3'b000:  return (b >= 128) ? (32'(b) | 32'hFFFF_FF00) : 32'(b);
      3'b001:  return (h >= 32768) ? (32'(h) | 32'hFFFF_0000) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin : model
    ment_t e;
    bit    do_push;
    bit    do_pop;

    if (reset) begin
      mq.delete();
      m_instret = 64'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && out_ready;

      e.ex  = ex_result;
      e.pc  = pc;
      e.rd  = rd;
      e.csr = csr_wen;
      e.rw  = r_wen;

      if (jump_flag || (csr_wen != 4'd0)) begin
        e.res = rd_value;
      end else if (mem_ren) begin
        e.res = fmt_load(mem_rdata, ex_result[1:0], mem_funct3);
      end else begin
        e.res = ex_result;
      end

      if (do_pop) begin
        void'(mq.pop_front());
        m_instret = m_instret + 64'd1;
      end

      if (do_push) begin
        mq.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: DUT outputs against the model, every falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin : compare
    ment_t h;
    bit    ev;

    ev = (mq.size() > 0);
    if (ev) begin
      h = mq[0];
    end

    check("cmp_out_valid", 64'(out_valid), 64'(ev));
    check("cmp_in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    check("cmp_instret",   instret,        m_instret);

    if (ev) begin
      check("cmp_r_wen_next",    64'(r_wen_next),    64'(h.rw && (h.rd != 5'd0)));
      check("cmp_rd_next",       64'(rd_next),       64'(h.rd));
      check("cmp_rd_value_next", 64'(rd_value_next), 64'(h.res));
      check("cmp_csr_wen_next",  64'(csr_wen_next),  64'(h.csr));
      check("cmp_csrd",          64'(csrd),          64'(h.ex));
      check("cmp_pc_out",        64'(pc_out),        64'(h.pc));
    end else begin
      check("cmp_idle_outputs",
            64'({r_wen_next, rd_next, csr_wen_next}) | 64'(rd_value_next)
              | 64'(csrd) | 64'(pc_out),
            64'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_in(input logic [31:0] mem, input logic [31:0] ex,
                        input logic [31:0] rv,  input logic [4:0]  rdv,
                        input logic [3:0]  csr, input logic        rw,
                        input logic        mr,  input logic [2:0]  f3,
                        input logic        jf);
    mem_rdata  = mem;
    ex_result  = ex;
    rd_value   = rv;
    rd         = rdv;
    csr_wen    = csr;
    r_wen      = rw;
    mem_ren    = mr;
    mem_funct3 = f3;
    jump_flag  = jf;
    pc         = pc + 32'd4;
    in_valid   = 1'b1;
  endtask

  logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
  logic [1:0]  off_tab [5] = '{2'd3,   2'd3,   2'd2,   2'd0,   2'd0};
  logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h0000_0001};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    mem_rdata  = '0;
    ex_result  = '0;
    rd_value   = '0;
    rd         = '0;
    csr_wen    = '0;
    r_wen      = 1'b0;
    mem_ren    = 1'b0;
    mem_funct3 = '0;
    jump_flag  = 1'b0;
    pc         = 32'h0000_1000;

    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_instret",   instret,        64'd0);

    // LW, one-cycle latency, then the pop counts as a retirement.
    out_ready = 1'b1;
    set_in(32'hDEAD_BEEF, 32'h100, 32'h0, 5'd5, 4'd0, 1'b1, 1'b1, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    check("lw_out_valid", 64'(out_valid),     64'd1);
    check("lw_value",     64'(rd_value_next), 64'hDEAD_BEEF);
    check("lw_r_wen",     64'(r_wen_next),    64'd1);
    check("lw_rd",        64'(rd_next),       64'd5);
    step();
    check("lw_instret",   instret,            64'd1);

    // Load formatting table.
    for (int i = 0; i < 5; i++) begin
      set_in(32'h80FF_7F01, 32'h200 | 32'(off_tab[i]), 32'h0, 5'(i + 1),
             4'd0, 1'b1, 1'b1, f3_tab[i], 1'b0);
      step();
      in_valid = 1'b0;
      check("fmt_value", 64'(rd_value_next), 64'(exp_tab[i]));
      step();
    end

    // Backpressure: fill, reject a third entry, drain in order.
    out_ready = 1'b0;
    set_in(32'h0, 32'hA0, 32'h0, 5'd10, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    set_in(32'h0, 32'hB0, 32'h0, 5'd11, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    check("full_in_ready", 64'(in_ready), 64'd0);

    set_in(32'h0, 32'hC0, 32'h0, 5'd12, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    check("full_head_a",      64'(rd_next),  64'd10);
    check("full_still_ready", 64'(in_ready), 64'd0);

    out_ready = 1'b1;
    step();
    check("drain_head_b",   64'(rd_next),  64'd11);
    check("drain_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("drain_head_c", 64'(rd_next), 64'd12);
    step();
    check("drain_empty",   64'(out_valid), 64'd0);
    check("drain_instret", instret,        64'd9);

    // Jump selects rd_value over ex_result.
    set_in(32'h0, 32'h2000, 32'h1004, 5'd1, 4'd0, 1'b1, 1'b0, 3'b010, 1'b1);
    step();
    in_valid = 1'b0;
    check("jump_value", 64'(rd_value_next), 64'h1004);
    check("jump_csr",   64'(csr_wen_next),  64'd0);
    step();

    // CSR instruction, with mem_ren also set to show priority.
    set_in(32'h1234, 32'h3000, 32'h55, 5'd2, 4'b0001, 1'b1, 1'b1, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    check("csr_wen",   64'(csr_wen_next),  64'd1);
    check("csr_csrd",  64'(csrd),          64'h3000);
    check("csr_value", 64'(rd_value_next), 64'h55);
    step();

    // Writes to x0 are suppressed.
    set_in(32'h0, 32'h77, 32'h0, 5'd0, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    check("x0_out_valid", 64'(out_valid),  64'd1);
    check("x0_r_wen",     64'(r_wen_next), 64'd0);
    step();

    // Flush a full FIFO while in_valid and out_ready are both high.
    out_ready = 1'b0;
    set_in(32'h0, 32'h20, 32'h0, 5'd20, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    set_in(32'h0, 32'h21, 32'h0, 5'd21, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    set_in(32'h0, 32'h22, 32'h0, 5'd22, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    check("flush_instret",   instret,        64'd12);
    step();

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b0;
    set_in(32'h0, 32'h30, 32'h0, 5'd3, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    set_in(32'h0, 32'h40, 32'h0, 5'd4, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid),     64'd0);
    check("arst_in_ready",  64'(in_ready),      64'd1);
    check("arst_rd",        64'(rd_next),       64'd0);
    check("arst_value",     64'(rd_value_next), 64'd0);
    check("arst_pc",        64'(pc_out),        64'd0);
    check("arst_instret",   instret,            64'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // Normal operation resumes after reset.
    out_ready = 1'b1;
    set_in(32'h0, 32'h66, 32'h0, 5'd6, 4'd0, 1'b1, 1'b0, 3'b010, 1'b0);
    step();
    in_valid = 1'b0;
    check("post_rd",      64'(rd_next), 64'd6);
    check("post_instret", instret,      64'd0);
    step();
    check("post_instret_1", instret, 64'd1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
